// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: execute-stage requests, CSR direct-write ports
// and the fetch redirect handshake.
interface trap_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        req_illegal;
  logic        req_ebreak;
  logic        req_ecall;
  logic        req_mret;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic [63:0] mepc_in;
  logic        mepc_wen;
  logic [63:0] mcause_in;
  logic        mcause_wen;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  modport master (
    output req_valid, req_pc, req_illegal, req_ebreak,
    output req_ecall, req_mret, mtvec, mepc, redirect_ready,
    input  req_ready, mepc_in, mepc_wen, mcause_in,
    input  mcause_wen, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  req_valid, req_pc, req_illegal, req_ebreak,
    input  req_ecall, req_mret, mtvec, mepc, redirect_ready,
    output req_ready, mepc_in, mepc_wen, mcause_in,
    output mcause_wen, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: saves mepc/mcause on exceptions, then redirects
// fetch to mtvec (trap) or mepc (mret).
module trap_ctrl (
  input logic       clk,
  input logic       rst_n,
  trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    JUMP = 2'd2
  } state_t;

  state_t      state;
  logic        kind_ret;
  logic        ready_q;
  logic        busy_q;
  logic        rv_q;
  logic        wen_q;
  logic [63:0] pc_q;
  logic [3:0]  cause_q;
  logic [3:0]  cause_c;
  logic        trap_hit;
  logic        accept;
  logic [63:0] tgt;

  assign accept   = bus.req_valid & ready_q;
  assign trap_hit = bus.req_illegal | bus.req_ebreak
                  | bus.req_ecall;

  // illegal > ebreak > ecall
  always_comb begin
    cause_c = 4'd11;
    if (bus.req_illegal)     cause_c = 4'd2;
    else if (bus.req_ebreak) cause_c = 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      kind_ret <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      wen_q    <= 1'b0;
      pc_q     <= '0;
      cause_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept && trap_hit) begin
            state    <= SAVE;
            kind_ret <= 1'b0;
            pc_q     <= bus.req_pc & ~64'd3;
            cause_q  <= cause_c;
            wen_q    <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end else if (accept && bus.req_mret) begin
            state    <= JUMP;
            kind_ret <= 1'b1;
            rv_q     <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        SAVE: begin
          state <= JUMP;
          wen_q <= 1'b0;
          rv_q  <= 1'b1;
        end
        JUMP: begin
          if (bus.redirect_ready) begin
            state   <= IDLE;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          wen_q   <= 1'b0;
          rv_q    <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign tgt = kind_ret ? bus.mepc : bus.mtvec;

  assign bus.req_ready      = ready_q;
  assign bus.busy           = busy_q;
  assign bus.mepc_wen       = wen_q;
  assign bus.mcause_wen     = wen_q;
  assign bus.mepc_in        = pc_q;
  assign bus.mcause_in      = {60'd0, cause_q};
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rv_q ? (tgt & ~64'd3) : '0;
endmodule
